mem_bus_responder: RTL
======================

// Module: mem_bus_responder
// PURPOSE
//   Memory-side responder for the CPU control unit's memory request bus.
//   Accepts 16-bit word read/write requests over a req/ack handshake.
//   Serves them from a byte-wide store, high byte first (big-endian), as two sequential byte accesses.
//   Sits between Control/MAR/MBR and storage; replaces direct MainMemory access with a timed, checked protocol.
// PARAMETERS
//   ADDR_WIDTH  14  byte-address bits actually backed by storage (depth = 2**ADDR_WIDTH bytes)
//   DATA_WIDTH  16  word width on the bus; fixed at 2 bytes
// PORTS
//   clock   in   1   single system clock, all state updates on posedge
//   reset   in   1   synchronous, active-high reset
//   req     in   1   initiator request; sampled only in IDLE
//   we      in   1   1 = write, 0 = read; captured with req
//   addr    in   16  byte address of high byte; captured with req
//   wdata   in   16  write word; captured with req
//   ack     out  1   one-cycle completion pulse
//   err     out  1   valid with ack; 1 = address out of range
//   rdata   out  16  read word; valid with ack on reads
//   busy    out  1   high from cycle after acceptance through ack cycle
// BEHAVIOUR
//   Reset (sync, active-high, priority over all else):
//     - state = IDLE; ack = 0, err = 0, busy = 0, rdata = 16'h0000.
//     - Storage contents are not cleared.
//   States: IDLE -> HI -> LO -> ACK -> IDLE.
//   IDLE:
//     - If req=1 at posedge, latch addr/we/wdata; busy <= 1.
//     - If addr[15:ADDR_WIDTH] != 0: go directly to ACK with err=1. No storage access occurs.
//     - Otherwise go to HI.
//   HI:
//     - Read: capture mem[a] into rdata[15:8] staging.
//     - Write: mem[a] <= wdata[15:8].
//     - Go to LO.
//   LO:
//     - Use a1 = (a+1) mod 2**ADDR_WIDTH; top byte wraps to 0.
//     - Read: capture mem[a1] into the low staging byte.
//     - Write: mem[a1] <= wdata[7:0].
//     - Go to ACK.
//   ACK:
//     - ack = 1 for exactly this cycle; err valid.
//     - On a good read, rdata updates to the staged word in this cycle.
//     - rdata holds its value on writes and errors.
//     - Next state IDLE; busy = 0 from the next cycle.
//   Latency (req accepted at edge N):
//     - In-range: ack high in the cycle after edge N+2.
//     - Error: ack high in the cycle after edge N.
//   Handshake:
//     - req is ignored outside IDLE.
//     - If req is still high on return to IDLE, a new transaction starts (back-to-back every 4 cycles).
//     - Unaligned (odd) addresses are legal.
//   Reset mid-transaction aborts it: no ack. A byte already written in HI remains written.
// TESTING
//   1. Write 16'hBEEF @16'h0010, then read @16'h0010 -> rdata=16'hBEEF, err=0, ack 3 cycles after accept, 1 cycle wide.
//   2. Write 16'h1234 @16'h0020, write 16'h5678 @16'h0021, read @16'h0020 -> 16'h1256.
//   3. Write 16'hA55A @16'h3FFF -> read @16'h3FFF = 16'hA55A; read @16'h0000 high byte = 8'h5A.
//   4. Read @16'h4000 -> ack+err 1 cycle after accept, rdata unchanged; write 16'hFFFF @16'h8000 -> mem @16'h0000 unchanged.
//   5. mem @16'h0030 = 16'h0000; write 16'h1111 @16'h0030; reset during LO -> no ack, busy=0, read @16'h0030 = 16'h1100.
//   6. Hold req=1 for 12 cycles (reads) -> exactly 3 acks, spaced 4 cycles apart; address changes while busy are ignored.

Source files
------------

// File: rtl/mem_bus_responder.sv
// Word-wide memory responder over a req/ack handshake.
// Backed by a byte store, accessed high byte first.
module mem_bus_responder #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [15:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO,
    ACK
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   a_q;
  logic                    we_q;
  logic [DATA_WIDTH-1:0]   wd_q;
  logic [7:0]              hi_q;
  logic                    ack_q;
  logic                    err_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic [7:0]              mem [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0]   a1;
  logic                    oor;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_a;
  logic [7:0]              wr_b;

  // Low byte address wraps inside the backed range.
  assign a1  = a_q + ADDR_WIDTH'(1);
  assign oor = (addr >> ADDR_WIDTH) != '0;

  always_comb begin
    wr_en = 1'b0;
    wr_a  = a_q;
    wr_b  = wd_q[15:8];
    unique case (state_q)
      HI: wr_en = we_q;
      LO: begin
        wr_en = we_q;
        wr_a  = a1;
        wr_b  = wd_q[7:0];
      end
      default: ;
    endcase
  end

  // Reset wins over a pending byte write; contents are never cleared.
  always_ff @(posedge clock) begin
    if (!reset && wr_en) mem[wr_a] <= wr_b;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          err_q <= 1'b0;
          if (req) begin
            a_q    <= addr[ADDR_WIDTH-1:0];
            we_q   <= we;
            wd_q   <= wdata;
            busy_q <= 1'b1;
            if (oor) begin
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ACK;
            end else begin
              state_q <= HI;
            end
          end
        end
        HI: begin
          if (!we_q) hi_q <= mem[a_q];
          state_q <= LO;
        end
        LO: begin
          if (!we_q) rdata_q <= {hi_q, mem[a1]};
          ack_q   <= 1'b1;
          err_q   <= 1'b0;
          state_q <= ACK;
        end
        ACK: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;

endmodule
